// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions: write FSM encoding, default image geometry
// and a saturating counter helper.
package fb_pkg;

  localparam int FB_IMG_WIDTH  = 160;
  localparam int FB_IMG_HEIGHT = 120;

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_WRITE = 2'd1,
    W_DONE  = 2'd2
  } wr_state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/fb_bank_ram.sv
// Simple dual-port RAM holding both frame banks; one write port and one
// registered read port, both addressed as {bank, pixel_addr}.
module fb_bank_ram #(
  parameter int PIX_COUNT  = 19200,
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH:0]   waddr,
  input  logic [15:0]           wdata,
  input  logic [ADDR_WIDTH:0]   raddr,
  output logic [15:0]           rd_data_q
);

  localparam int DEPTH = 2 * PIX_COUNT;
  localparam logic [ADDR_WIDTH:0] BANK1_BASE = (ADDR_WIDTH + 1)'(PIX_COUNT);

  logic [15:0] mem [DEPTH];

  // Bank 1 starts right after bank 0 so the array is exactly two frames deep.
  function automatic logic [ADDR_WIDTH:0] lin(input logic [ADDR_WIDTH:0] a);
    return a[ADDR_WIDTH] ? BANK1_BASE + {1'b0, a[ADDR_WIDTH-1:0]}
                         : {1'b0, a[ADDR_WIDTH-1:0]};
  endfunction

  always_ff @(posedge clk) begin
    if (we) mem[lin(waddr)] <= wdata;
    rd_data_q <= mem[lin(raddr)];
  end

endmodule

// File: rtl/frame_buffer_pingpong.sv
// Ping-pong frame store: capture writes one bank while filters read the other;
// banks swap only on a display frame boundary once a full frame is stored.
module frame_buffer_pingpong
  import fb_pkg::*;
#(
  parameter  int IMG_WIDTH  = FB_IMG_WIDTH,
  parameter  int IMG_HEIGHT = FB_IMG_HEIGHT,
  localparam int PIX_COUNT  = IMG_WIDTH * IMG_HEIGHT,
  localparam int ADDR_WIDTH = $clog2(PIX_COUNT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_frame_start,
  input  logic                  wr_valid,
  input  logic [15:0]           wr_data,
  input  logic                  rd_frame_start,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [15:0]           frame_buffer_data,
  output logic                  frame_valid,
  output logic [7:0]            drop_cnt,
  output logic [7:0]            short_cnt,
  output wr_state_t             dbg_wr_state,
  output logic                  dbg_wr_bank
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PIX_COUNT - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);

  wr_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wr_bank_q, wr_bank_d;
  logic                  valid_q, valid_d;
  logic                  rd_ok_q, rd_ok_d;
  logic [7:0]            drop_q, drop_d;
  logic [7:0]            short_q, short_d;
  logic                  we;
  logic [ADDR_WIDTH-1:0] we_addr;
  logic                  rd_in_range;
  logic [ADDR_WIDTH-1:0] rd_addr_eff;
  logic [15:0]           ram_rdata;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wr_bank_d = wr_bank_q;
    valid_d   = valid_q;
    drop_d    = drop_q;
    short_d   = short_q;
    we        = 1'b0;
    we_addr   = addr_q;
    case (state_q)
      W_IDLE: begin
        if (wr_frame_start) begin
          addr_d  = '0;
          state_d = W_WRITE;
        end
      end
      W_WRITE: begin
        // A restart may carry the first pixel of the new frame.
        if (wr_frame_start) begin
          short_d = sat_inc(short_q);
          we      = wr_valid;
          we_addr = '0;
          addr_d  = wr_valid ? ONE : '0;
        end else if (wr_valid) begin
          we = 1'b1;
          if (addr_q == LAST_ADDR) begin
            addr_d  = '0;
            state_d = W_DONE;
          end else begin
            addr_d = addr_q + ONE;
          end
        end
      end
      W_DONE: begin
        if (rd_frame_start) begin
          wr_bank_d = ~wr_bank_q;
          valid_d   = 1'b1;
          addr_d    = '0;
          state_d   = wr_frame_start ? W_WRITE : W_IDLE;
        end else if (wr_frame_start) begin
          drop_d = sat_inc(drop_q);
        end
      end
      default: state_d = W_IDLE;
    endcase
  end

  // Read port has no handshake: address in cycle N, data in cycle N+1.
  // Out-of-range or not-yet-valid reads return zero.
  always_comb begin
    rd_in_range = (read_addr <= LAST_ADDR);
    rd_addr_eff = rd_in_range ? read_addr : '0;
    rd_ok_d     = rd_in_range & valid_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= W_IDLE;
      addr_q    <= '0;
      wr_bank_q <= 1'b0;
      valid_q   <= 1'b0;
      rd_ok_q   <= 1'b0;
      drop_q    <= '0;
      short_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wr_bank_q <= wr_bank_d;
      valid_q   <= valid_d;
      rd_ok_q   <= rd_ok_d;
      drop_q    <= drop_d;
      short_q   <= short_d;
    end
  end

  fb_bank_ram #(
    .PIX_COUNT  (PIX_COUNT),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk       (clk),
    .we        (we),
    .waddr     ({wr_bank_q, we_addr}),
    .wdata     (wr_data),
    .raddr     ({~wr_bank_q, rd_addr_eff}),
    .rd_data_q (ram_rdata)
  );

  assign frame_buffer_data = rd_ok_q ? ram_rdata : 16'h0000;
  assign frame_valid       = valid_q;
  assign drop_cnt          = drop_q;
  assign short_cnt         = short_q;
  assign dbg_wr_state      = state_q;
  assign dbg_wr_bank       = wr_bank_q;

endmodule

// File: tb/tb_frame_buffer_pingpong.sv
// Bench for frame_buffer_pingpong: table vectors after reset, full-frame
// sequences with random reads, and a frame-level reference model.
module tb_frame_buffer_pingpong;
  import fb_pkg::*;

  localparam int PIX = FB_IMG_WIDTH * FB_IMG_HEIGHT;
  localparam int AW  = $clog2(PIX);

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic          wr_frame_start, wr_valid, rd_frame_start;
  logic [15:0]   wr_data;
  logic [AW-1:0] read_addr;
  logic [15:0]   frame_buffer_data;
  logic          frame_valid;
  logic [7:0]    drop_cnt, short_cnt;
  wr_state_t     dbg_wr_state;
  logic          dbg_wr_bank;

  always #5 clk = ~clk;

  frame_buffer_pingpong dut (
    .clk               (clk),
    .reset             (reset),
    .wr_frame_start    (wr_frame_start),
    .wr_valid          (wr_valid),
    .wr_data           (wr_data),
    .rd_frame_start    (rd_frame_start),
    .read_addr         (read_addr),
    .frame_buffer_data (frame_buffer_data),
    .frame_valid       (frame_valid),
    .drop_cnt          (drop_cnt),
    .short_cnt         (short_cnt),
    .dbg_wr_state      (dbg_wr_state),
    .dbg_wr_bank       (dbg_wr_bank)
  );

  // ---------------- scoreboard / model ----------------
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];

  logic [15:0] m_front [PIX];  // frame the filters see
  logic [15:0] m_back  [PIX];  // frame being captured
  bit          m_valid, m_full, m_bank;
  int          m_cnt;          // pixels received in current frame, -1 if none in progress
  int          m_drop, m_short;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_read(input int a);
    return (m_valid && a < PIX) ? m_front[a] : 16'h0000;
  endfunction

  function automatic wr_state_t model_state();
    if (m_full) return W_DONE;
    if (m_cnt >= 0) return W_WRITE;
    return W_IDLE;
  endfunction

  function automatic int sat8(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_full = 0; m_bank = 0; m_cnt = -1; m_drop = 0; m_short = 0;
    exp_q.delete();
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit wfs, input bit wv, input logic [15:0] wd,
                      input bit rfs, input int ra);
    wr_frame_start = wfs;
    wr_valid       = wv;
    wr_data        = wd;
    rd_frame_start = rfs;
    read_addr      = AW'(ra);
    exp_q.push_back(model_read(ra));
    // Frame-level rules: a finished frame is shown at the next display start;
    // while a finished frame waits, new capture frames are dropped.
    if (rfs && m_full) begin
      m_front = m_back;
      m_valid = 1; m_full = 0; m_bank = ~m_bank;
      m_cnt   = wfs ? 0 : -1;
    end else if (m_full) begin
      if (wfs) m_drop = sat8(m_drop);
    end else if (m_cnt >= 0) begin
      if (wfs) begin
        m_short = sat8(m_short);
        m_cnt   = 0;
      end
      if (wv) begin
        m_back[m_cnt] = wd;
        m_cnt++;
        if (m_cnt == PIX) begin
          m_full = 1;
          m_cnt  = -1;
        end
      end
    end else if (wfs) begin
      m_cnt = 0;
    end
    @(posedge clk);
    #1;
    check("read_data", frame_buffer_data, exp_q.pop_front());
    check("frame_valid", frame_valid, m_valid);
    check("drop_cnt", drop_cnt, m_drop);
    check("short_cnt", short_cnt, m_short);
    check("wr_state", dbg_wr_state, model_state());
    check("wr_bank", dbg_wr_bank, m_bank);
  endtask

  task automatic reset_dut();
    reset = 1; wr_frame_start = 0; wr_valid = 0; wr_data = '0;
    rd_frame_start = 0; read_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    model_reset();
  endtask

  function automatic int rand_addr();
    return $urandom_range(0, PIX + 63);
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    bit          wfs;
    bit          wv;
    logic [15:0] wd;
    bit          rfs;
    int          ra;
    logic [15:0] e_data;
    bit          e_valid;
    wr_state_t   e_state;
  } vec_t;

  vec_t vt [6];

  initial begin
    int a;
    bit wv;

    vt[0] = '{0, 0, 16'h0000, 0, 5,     16'h0000, 0, W_IDLE};
    vt[1] = '{0, 0, 16'h0000, 1, 100,   16'h0000, 0, W_IDLE};
    vt[2] = '{0, 1, 16'h1234, 0, 0,     16'h0000, 0, W_IDLE};
    vt[3] = '{0, 0, 16'h0000, 0, 32767, 16'h0000, 0, W_IDLE};
    vt[4] = '{1, 0, 16'h0000, 0, 0,     16'h0000, 0, W_WRITE};
    vt[5] = '{0, 1, 16'h0000, 0, 0,     16'h0000, 0, W_WRITE};

    reset_dut();
    check("rst_data", frame_buffer_data, 16'h0000);
    check("rst_valid", frame_valid, 1'b0);
    check("rst_state", dbg_wr_state, W_IDLE);

    for (int i = 0; i < 6; i++) begin
      step(vt[i].wfs, vt[i].wv, vt[i].wd, vt[i].rfs, vt[i].ra);
      check("vec_data", frame_buffer_data, vt[i].e_data);
      check("vec_valid", frame_valid, vt[i].e_valid);
      check("vec_state", dbg_wr_state, vt[i].e_state);
    end

    // Frame 1: data = addr, pixel 0 already written by the table.
    for (int p = 1; p < PIX; p++)
      step(0, 1, 16'(p), ($urandom_range(0, 15) == 0), rand_addr());
    check("f1_done", dbg_wr_state, W_DONE);
    step(0, 0, 16'h0, 0, 100);
    check("f1_hidden", frame_buffer_data, 16'h0000);
    step(0, 0, 16'h0, 1, 100);
    step(0, 0, 16'h0, 0, 100);
    check("f1_read100", frame_buffer_data, 16'h0064);
    check("f1_valid", frame_valid, 1'b1);
    step(0, 0, 16'h0, 0, PIX);
    check("f1_oob", frame_buffer_data, 16'h0000);

    // Frame 2: data = ~addr with gaps and random reads during capture.
    step(1, 0, 16'h0, 0, rand_addr());
    a = 0;
    while (a < PIX) begin
      wv = ($urandom_range(0, 3) != 0);
      step(0, wv, ~16'(a), ($urandom_range(0, 15) == 0), rand_addr());
      if (wv) a++;
    end
    for (int i = 0; i < 20; i++) step(0, 0, 16'h0, 0, rand_addr());
    step(0, 0, 16'h0, 0, 200);
    check("f2_old200", frame_buffer_data, 16'h00C8);
    step(0, 0, 16'h0, 1, 7);
    check("f2_swapcyc", frame_buffer_data, 16'h0007);
    step(0, 0, 16'h0, 0, 7);
    check("f2_read7", frame_buffer_data, 16'hFFF8);

    // Short frame: restart after 500 pixels, restart cycle carries pixel 0.
    step(1, 0, 16'h0, 0, rand_addr());
    for (int p = 0; p < 500; p++)
      step(0, 1, 16'($urandom), 0, rand_addr());
    step(1, 1, 16'hA5A5, 0, rand_addr());
    check("short_one", short_cnt, 8'd1);
    for (int p = 1; p < PIX; p++)
      step(0, 1, 16'(p) ^ 16'hA5A5, (p == PIX - 1), rand_addr());
    check("cmpl_rfs_state", dbg_wr_state, W_DONE);
    step(0, 0, 16'h0, 0, 7);
    check("cmpl_rfs_noswap", frame_buffer_data, 16'hFFF8);

    // Drops while a finished frame waits, then start coinciding with swap.
    step(1, 0, 16'h0, 0, rand_addr());
    step(1, 1, 16'h0, 0, rand_addr());
    check("drop_two", drop_cnt, 8'd2);
    step(1, 0, 16'h0, 1, 3);
    check("swap_start_state", dbg_wr_state, W_WRITE);
    check("swap_start_drop", drop_cnt, 8'd2);
    step(0, 0, 16'h0, 0, 3);
    check("f3_read3", frame_buffer_data, 16'hA5A6);
    for (int p = 0; p < 100; p++)
      step(0, 1, 16'($urandom), 0, rand_addr());

    // Reset in the middle of a capture frame.
    reset_dut();
    check("mid_rst_state", dbg_wr_state, W_IDLE);
    check("mid_rst_bank", dbg_wr_bank, 1'b0);
    check("mid_rst_valid", frame_valid, 1'b0);
    check("mid_rst_drop", drop_cnt, 8'd0);
    check("mid_rst_short", short_cnt, 8'd0);
    step(0, 0, 16'h0, 0, 3);
    check("mid_rst_hidden", frame_buffer_data, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
